// File: rtl/ehr_fifo_pkg.sv
// ehr_fifo_pkg: shared ordering-mode constants and width helpers for ehr_fifo
// Contents:
//   MODE_PIPELINE / MODE_BYPASS / MODE_CF - intra-cycle enq/deq ordering selectors
//   ptr_w(depth)  - head/tail pointer width
//   cnt_w(depth)  - occupancy counter width (holds 0..depth)
package ehr_fifo_pkg;

    localparam int MODE_PIPELINE = 0;
    localparam int MODE_BYPASS   = 1;
    localparam int MODE_CF       = 2;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ehr_fifo_ehr_n.sv
// ehr_n: N-port ephemeral history register
// Ports:
//   clk, rst         - clock, synchronous active-high reset (value clears to 0)
//   wr_en_i[i]       - port i writes this cycle
//   wr_data_i[i]     - port i write value
//   rd_data_o[i]     - value port i observes: register after writes of ports < i
//   q_o              - registered value (same as rd_data_o[0], loop-free for feedback use)
// Commit takes the highest-numbered port that wrote.
module ehr_n #(
    parameter int WIDTH = 1,
    parameter int PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PORTS-1:0]             wr_en_i,
    input  logic [PORTS-1:0][WIDTH-1:0]  wr_data_i,
    output logic [PORTS-1:0][WIDTH-1:0]  rd_data_o,
    output logic [WIDTH-1:0]             q_o
);

    logic [WIDTH-1:0]            val_q;
    logic [WIDTH-1:0]            val_d;
    logic [PORTS:0][WIDTH-1:0]   chain;

    always_comb begin
        chain[0] = val_q;
        for (int i = 0; i < PORTS; i++)
            chain[i+1] = wr_en_i[i] ? wr_data_i[i] : chain[i];
    end

    assign rd_data_o = chain[PORTS-1:0];
    assign val_d     = chain[PORTS];
    assign q_o       = val_q;

    always_ff @(posedge clk) begin
        if (rst)
            val_q <= '0;
        else
            val_q <= val_d;
    end

endmodule

// File: rtl/ehr_fifo.sv
// ehr_fifo: parametrised FIFO with EHR-held head/tail/count and selectable enq/deq ordering
// Parameters: WIDTH (data bits), DEPTH (entries, >=2), MODE (0 pipeline, 1 bypass, 2 conflict-free)
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   enq_en, enq_data, enq_rdy   - enqueue request, payload, ready
//   deq_en, deq_data, deq_rdy   - dequeue request, head payload, ready
//   clear                       - flush; ordered after enq and deq, overrides both
// Optional: define EHR_FIFO_ASSERT_EN for simulation checks on illegal requests,
// counter overflow and illegal MODE/DEPTH.
module ehr_fifo
    import ehr_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int MODE  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_en,
    input  logic [WIDTH-1:0] enq_data,
    output logic             enq_rdy,
    input  logic             deq_en,
    output logic [WIDTH-1:0] deq_data,
    output logic             deq_rdy,
    input  logic             clear
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    // EHR port order: the earlier method sits on the lower port, clear is always last.
    localparam int PE = (MODE == MODE_BYPASS) ? 0 : 1;
    localparam int PD = 1 - PE;
    localparam int PC = 2;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [2:0]             head_we, tail_we, cnt_we;
    logic [2:0][PW-1:0]     head_wd, head_rd, tail_wd, tail_rd;
    logic [2:0][CW-1:0]     cnt_wd, cnt_rd;
    logic [PW-1:0]          head_q, tail_q;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          enq_view, deq_view;
    logic                   full, empty;
    logic                   enq_fire, deq_fire, pass, enq_do, deq_do;
    logic                   unused_rd;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;

    assign enq_rdy  = (MODE == MODE_PIPELINE) ? (!full || deq_en) : !full;
    assign deq_rdy  = (MODE == MODE_BYPASS) ? (!empty || enq_en) : !empty;
    assign deq_data = (MODE == MODE_BYPASS && empty) ? enq_data : mem_q[head_rd[PD]];

    assign enq_fire = enq_en && enq_rdy;
    assign deq_fire = deq_en && deq_rdy;
    // Bypass on empty hands enq_data straight through; the queue itself is untouched.
    assign pass     = (MODE == MODE_BYPASS) && empty && enq_fire && deq_fire;
    assign enq_do   = enq_fire && !pass;
    assign deq_do   = deq_fire && !pass;

    // Count each method observes at its EHR port, built from registered state so the
    // write data never feeds back through the EHR read chain.
    assign enq_view = (PD < PE) ? count_q - CW'(deq_do) : count_q;
    assign deq_view = (PE < PD) ? count_q + CW'(enq_do) : count_q;

    always_comb begin
        head_we     = '0;
        head_wd     = '0;
        tail_we     = '0;
        tail_wd     = '0;
        cnt_we      = '0;
        cnt_wd      = '0;
        head_we[PD] = deq_do;
        head_wd[PD] = wrap_inc(head_q);
        tail_we[PE] = enq_do;
        tail_wd[PE] = wrap_inc(tail_q);
        cnt_we[PD]  = deq_do;
        cnt_wd[PD]  = deq_view - 1'b1;
        cnt_we[PE]  = enq_do;
        cnt_wd[PE]  = enq_view + 1'b1;
        head_we[PC] = clear;
        tail_we[PC] = clear;
        cnt_we[PC]  = clear;
    end

    ehr_n #(.WIDTH(PW), .PORTS(3)) u_head (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (head_we),
        .wr_data_i (head_wd),
        .rd_data_o (head_rd),
        .q_o       (head_q)
    );

    ehr_n #(.WIDTH(PW), .PORTS(3)) u_tail (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (tail_we),
        .wr_data_i (tail_wd),
        .rd_data_o (tail_rd),
        .q_o       (tail_q)
    );

    ehr_n #(.WIDTH(CW), .PORTS(3)) u_count (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (cnt_we),
        .wr_data_i (cnt_wd),
        .rd_data_o (cnt_rd),
        .q_o       (count_q)
    );

    // In pipeline mode at full, tail equals head, so the new entry reuses the slot
    // being vacated in the same cycle.
    always_ff @(posedge clk) begin
        if (enq_do)
            mem_q[tail_rd[PE]] <= enq_data;
    end

`ifdef EHR_FIFO_ASSERT_EN
    assign unused_rd = ^{head_rd, tail_rd, cnt_rd[1:0]};

    if (MODE < MODE_PIPELINE || MODE > MODE_CF) begin : g_bad_mode
        $error("ehr_fifo: illegal MODE %0d", MODE);
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("ehr_fifo: illegal DEPTH %0d", DEPTH);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(enq_en && !enq_rdy)) else $error("ehr_fifo: enq_en without enq_rdy");
            assert (!(deq_en && !deq_rdy)) else $error("ehr_fifo: deq_en without deq_rdy");
            assert (count_q <= CW'(DEPTH) && cnt_rd[PC] <= CW'(DEPTH))
                else $error("ehr_fifo: count exceeds DEPTH");
        end
    end
`else
    assign unused_rd = ^{head_rd, tail_rd, cnt_rd};
`endif

endmodule

// File: tb/tb_ehr_fifo.sv
// tb_ehr_fifo: directed table-driven bench for ehr_fifo across all ordering modes
module tb_ehr_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       enq_en   [4];
    logic [7:0] enq_data [4];
    logic       enq_rdy  [4];
    logic       deq_en   [4];
    logic [7:0] deq_data [4];
    logic       deq_rdy  [4];
    logic       clear    [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // 0: MODE 2 DEPTH 2, 1: MODE 0 DEPTH 2, 2: MODE 1 DEPTH 2, 3: MODE 2 DEPTH 3
    for (genvar g = 0; g < 4; g++) begin : g_dut
        ehr_fifo #(
            .WIDTH (8),
            .DEPTH (g == 3 ? 3 : 2),
            .MODE  (g == 0 ? 2 : g == 1 ? 0 : g == 2 ? 1 : 2)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .enq_en   (enq_en[g]),
            .enq_data (enq_data[g]),
            .enq_rdy  (enq_rdy[g]),
            .deq_en   (deq_en[g]),
            .deq_data (deq_data[g]),
            .deq_rdy  (deq_rdy[g]),
            .clear    (clear[g])
        );
    end

    typedef struct {
        int         d;
        logic       ee;
        logic [7:0] ed;
        logic       de;
        logic       cl;
        logic       er;
        logic       dr;
        logic [7:0] dd;
        logic       cd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int d, input logic ee, input logic [7:0] ed, input logic de,
                       input logic cl, input logic er, input logic dr, input logic [7:0] dd,
                       input logic cd);
        vec_t v;
        v.d = d; v.ee = ee; v.ed = ed; v.de = de; v.cl = cl;
        v.er = er; v.dr = dr; v.dd = dd; v.cd = cd;
        vecs.push_back(v);
    endtask

    task automatic drive(input int d, input logic ee, input logic [7:0] ed, input logic de,
                         input logic cl);
        for (int i = 0; i < 4; i++) begin
            enq_en[i]   = 1'b0;
            enq_data[i] = 8'h00;
            deq_en[i]   = 1'b0;
            clear[i]    = 1'b0;
        end
        enq_en[d]   = ee;
        enq_data[d] = ed;
        deq_en[d]   = de;
        clear[d]    = cl;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int d, input logic er, input logic dr,
                              input logic [7:0] dd, input logic cd);
        check({tag, " enq_rdy"}, {7'b0, enq_rdy[d]}, {7'b0, er});
        check({tag, " deq_rdy"}, {7'b0, deq_rdy[d]}, {7'b0, dr});
        if (cd)
            check({tag, " deq_data"}, deq_data[d], dd);
    endtask

    // Drive one cycle's inputs just after the edge; outputs are sampled on the falling edge.
    task automatic cyc(input int d, input logic ee, input logic [7:0] ed, input logic de,
                       input logic cl);
        @(posedge clk);
        #1;
        drive(d, ee, ed, de, cl);
        @(negedge clk);
    endtask

    initial begin
        // MODE 2 DEPTH 2: fill, blocked enq at full, drain in order
        add(0, 1, 8'h0A, 0, 0, 1, 0, 8'h00, 0);
        add(0, 1, 8'h0B, 0, 0, 1, 1, 8'h0A, 1);
        add(0, 1, 8'h0C, 0, 0, 0, 1, 8'h0A, 1);
        add(0, 0, 8'h00, 1, 0, 0, 1, 8'h0A, 1);
        add(0, 0, 8'h00, 1, 0, 1, 1, 8'h0B, 1);
        add(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
        add(0, 1, 8'h07, 1, 0, 1, 0, 8'h00, 0);
        add(0, 0, 8'h00, 1, 0, 1, 1, 8'h07, 1);
        add(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
        // MODE 0 DEPTH 2: simultaneous enq/deq at full
        add(1, 1, 8'h01, 0, 0, 1, 0, 8'h00, 0);
        add(1, 1, 8'h02, 0, 0, 1, 1, 8'h01, 1);
        add(1, 0, 8'h00, 0, 0, 0, 1, 8'h01, 1);
        add(1, 1, 8'h03, 1, 0, 1, 1, 8'h01, 1);
        add(1, 0, 8'h00, 0, 0, 0, 1, 8'h02, 1);
        add(1, 0, 8'h00, 1, 0, 1, 1, 8'h02, 1);
        add(1, 0, 8'h00, 1, 0, 1, 1, 8'h03, 1);
        add(1, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
        // MODE 1 DEPTH 2: pass-through on empty, bypass data, full enq blocked
        add(2, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
        add(2, 1, 8'h55, 1, 0, 1, 1, 8'h55, 1);
        add(2, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
        add(2, 1, 8'h66, 0, 0, 1, 1, 8'h66, 1);
        add(2, 1, 8'h77, 0, 0, 1, 1, 8'h66, 1);
        add(2, 1, 8'h88, 1, 0, 0, 1, 8'h66, 1);
        add(2, 1, 8'h99, 1, 0, 1, 1, 8'h77, 1);
        add(2, 0, 8'h00, 1, 0, 1, 1, 8'h99, 1);
        add(2, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
        // MODE 2 DEPTH 3: clear overrides same-cycle enq/deq
        add(3, 1, 8'h01, 0, 0, 1, 0, 8'h00, 0);
        add(3, 1, 8'h02, 0, 0, 1, 1, 8'h01, 1);
        add(3, 1, 8'h09, 1, 1, 1, 1, 8'h01, 1);
        add(3, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
        add(3, 1, 8'h04, 0, 0, 1, 0, 8'h00, 0);
        add(3, 0, 8'h00, 1, 0, 1, 1, 8'h04, 1);
        add(3, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0);

        rst = 1'b1;
        drive(0, 0, 8'h00, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++)
            expect_out($sformatf("reset dut%0d", d), d, 1'b1, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].d, vecs[i].ee, vecs[i].ed, vecs[i].de, vecs[i].cl);
            expect_out($sformatf("vec%0d", i), vecs[i].d, vecs[i].er, vecs[i].dr,
                       vecs[i].dd, vecs[i].cd);
        end

        // DEPTH 3 pointer wrap: one entry in flight, seven enq/deq pairs
        cyc(3, 1, 8'h10, 0, 0);
        for (int k = 0; k < 7; k++) begin
            cyc(3, 1, 8'(8'h11 + k), 1, 0);
            expect_out($sformatf("wrap%0d", k), 3, 1'b1, 1'b1, 8'(8'h10 + k), 1'b1);
        end
        cyc(3, 0, 8'h00, 1, 0);
        expect_out("wrap last", 3, 1'b1, 1'b1, 8'h17, 1'b1);
        cyc(3, 0, 8'h00, 0, 0);
        expect_out("wrap empty", 3, 1'b1, 1'b0, 8'h00, 1'b0);

        // Reset mid-stream on the pipeline FIFO: entries lost, fires ignored
        cyc(1, 1, 8'h21, 0, 0);
        cyc(1, 1, 8'h22, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1, 1, 8'h23, 1, 0);
        @(negedge clk);
        expect_out("rst cycle", 1, 1'b1, 1'b1, 8'h21, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 0, 8'h00, 0, 0);
        @(negedge clk);
        expect_out("after rst", 1, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1, 1, 8'h24, 0, 0);
        cyc(1, 0, 8'h00, 1, 0);
        expect_out("post rst deq", 1, 1'b1, 1'b1, 8'h24, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
